math_accel_pipe: RTL and testbench

//  Parametrised streaming math stage between the ADC sample path and the DAC.
//  - Accepts signed two's-complement samples under a valid/ready handshake.
//  - Applies a per-sample selectable operation: square, absolute value, bipolar offset or mute.
//  - Rescales to an unsigned DAC code with saturation, through a stallable 3-stage pipeline.

---
 rtl/math_accel_if.sv | 28 ++
 rtl/math_accel_pipe.sv | 165 ++++++++++++++++
 tb/tb_math_accel_pipe.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/math_accel_if.sv
// Stream bus for math_accel_pipe: sample input handshake, DAC output handshake
// and the sticky saturation flag with its clear.
`timescale 1ns/1ps

interface math_accel_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 12
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  data_in;
  logic [1:0]              mode_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        data_out;
  logic                    sat_flag;
  logic                    sat_clr;

  modport master (
    output in_valid, data_in, mode_in, out_ready, sat_clr,
    input  in_ready, out_valid, data_out, sat_flag
  );

  modport slave (
    input  in_valid, data_in, mode_in, out_ready, sat_clr,
    output in_ready, out_valid, data_out, sat_flag
  );
endinterface

// File: rtl/math_accel_pipe.sv
// Stallable 3-stage math pipeline (square/abs/offset/mute) producing saturated DAC codes.
// Define MATH_ACCEL_AVG_EN to add an S4 block-averaging decimator of 2^AVG_LOG2 results.
`timescale 1ns/1ps

module math_accel_pipe #(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 12,
  parameter int AVG_LOG2 = 2
) (
  input logic          clk,
  input logic          rst_n,
  math_accel_if.slave  bus
);
  localparam logic [1:0] MODE_SQ   = 2'd0;
  localparam logic [1:0] MODE_ABS  = 2'd1;
  localparam logic [1:0] MODE_OFF  = 2'd2;
  localparam int SQ_SH  = 2*IN_W - 2 - OUT_W;
  localparam int ABS_SH = IN_W - 1 - OUT_W;
  localparam int OFF_SH = IN_W - OUT_W;

  if (IN_W <= OUT_W || AVG_LOG2 < 0) begin : g_bad_cfg
    $error("math_accel_pipe: IN_W must exceed OUT_W and AVG_LOG2 must be non-negative");
  end

  logic                 stall_s;
  logic                 v1_r;
  logic [IN_W-1:0]      x1_r;
  logic [1:0]           m1_r;
  logic                 v2_r;
  logic [OUT_W:0]       r2_r;
  logic                 v3_r;
  logic [OUT_W-1:0]     d3_r;
  logic                 sat_r;
  logic [OUT_W:0]       calc_s;
  logic [2*IN_W-1:0]    x_ext_s;
  logic [2*IN_W-1:0]    psq_s;
  logic [IN_W:0]        abs_s;
  logic [IN_W-1:0]      off_s;

  assign stall_s      = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall_s;
  assign bus.sat_flag = sat_r;

  // S2 arithmetic: every result fits OUT_W+1 bits, so bit OUT_W alone flags saturation
  always_comb begin
    x_ext_s = {{IN_W{x1_r[IN_W-1]}}, x1_r};
    psq_s   = x_ext_s * x_ext_s;
    if (x1_r[IN_W-1]) begin
      abs_s = {(IN_W+1){1'b0}} - {x1_r[IN_W-1], x1_r};
    end else begin
      abs_s = {1'b0, x1_r};
    end
    off_s = {~x1_r[IN_W-1], x1_r[IN_W-2:0]};
    case (m1_r)
      MODE_SQ:  calc_s = (OUT_W+1)'(psq_s >> SQ_SH);
      MODE_ABS: calc_s = (OUT_W+1)'(abs_s >> ABS_SH);
      MODE_OFF: calc_s = (OUT_W+1)'(off_s >> OFF_SH);
      default:  calc_s = {(OUT_W+1){1'b0}};
    endcase
  end

  // S1 capture and S2 compute; the whole pipe freezes on stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r <= 1'b0;
      x1_r <= {IN_W{1'b0}};
      m1_r <= 2'b00;
      v2_r <= 1'b0;
      r2_r <= {(OUT_W+1){1'b0}};
    end else if (!stall_s) begin
      v1_r <= bus.in_valid;
      x1_r <= bus.data_in;
      m1_r <= bus.mode_in;
      v2_r <= v1_r;
      r2_r <= calc_s;
    end
  end

  // S3 clamp, plus sticky saturation flag where clear beats a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_r  <= 1'b0;
      d3_r  <= {OUT_W{1'b0}};
      sat_r <= 1'b0;
    end else begin
      if (!stall_s) begin
        v3_r <= v2_r;
        d3_r <= r2_r[OUT_W] ? {OUT_W{1'b1}} : r2_r[OUT_W-1:0];
      end
      if (bus.sat_clr) begin
        sat_r <= 1'b0;
      end else if (!stall_s && v2_r && r2_r[OUT_W]) begin
        sat_r <= 1'b1;
      end
    end
  end

`ifdef MATH_ACCEL_AVG_EN
  localparam int ACC_W = OUT_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  logic [1:0]       m2_r;
  logic [1:0]       m3_r;
  logic [1:0]       last_mode_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             v4_r;
  logic [OUT_W-1:0] d4_r;
  logic             new_win_s;
  logic [ACC_W-1:0] sum_s;
  logic [CNT_W-1:0] base_cnt_s;
  logic             last_s;

  assign bus.out_valid = v4_r;
  assign bus.data_out  = d4_r;

  // A mode change restarts the window with the current result as its first element
  always_comb begin
    new_win_s  = (m3_r != last_mode_r);
    if (new_win_s) begin
      sum_s      = ACC_W'(d3_r);
      base_cnt_s = {CNT_W{1'b0}};
    end else begin
      sum_s      = acc_r + ACC_W'(d3_r);
      base_cnt_s = cnt_r;
    end
    last_s = (base_cnt_s == CNT_W'((1 << AVG_LOG2) - 1));
  end

  // Mode travels alongside S2/S3 and the S4 accumulator emits one mean per window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_r        <= 2'b00;
      m3_r        <= 2'b00;
      last_mode_r <= 2'b00;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      v4_r        <= 1'b0;
      d4_r        <= {OUT_W{1'b0}};
    end else if (!stall_s) begin
      m2_r <= m1_r;
      m3_r <= m2_r;
      if (v3_r) begin
        last_mode_r <= m3_r;
        if (last_s) begin
          v4_r  <= 1'b1;
          d4_r  <= OUT_W'(sum_s >> AVG_LOG2);
          acc_r <= {ACC_W{1'b0}};
          cnt_r <= {CNT_W{1'b0}};
        end else begin
          v4_r  <= 1'b0;
          acc_r <= sum_s;
          cnt_r <= base_cnt_s + CNT_W'(1);
        end
      end else begin
        v4_r <= 1'b0;
      end
    end
  end
`else
  assign bus.out_valid = v3_r;
  assign bus.data_out  = d3_r;
`endif

endmodule

// File: tb/tb_math_accel_pipe.sv
// Directed, table-driven bench for math_accel_pipe; covers the averaging build
// when MATH_ACCEL_AVG_EN is defined.
`timescale 1ns/1ps

module tb_math_accel_pipe;
  localparam int IN_W  = 16;
  localparam int OUT_W = 12;
  localparam logic [1:0] SQ = 2'd0, AB = 2'd1, OF = 2'd2, MU = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   q_data[$];
  int   q_sat[$];

  math_accel_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  math_accel_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .AVG_LOG2(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // output collector: one entry per completed output handshake
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      q_data.push_back(int'(bus.data_out));
      q_sat.push_back(int'(bus.sat_flag));
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drive one sample and hold it until the handshake edge (bounded wait)
  task automatic send(input logic [1:0] mode, input int x);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.data_in  = IN_W'(x);
    bus.mode_in  = mode;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    check("in_accept", int'(ok), 1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

`ifndef MATH_ACCEL_AVG_EN
  typedef struct {
    logic [1:0] mode;
    int         x;
    int         exp;
    int         sat;
  } vec_t;
  vec_t vecs[14];
`endif

  initial begin
    int flag_m;
    int held;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.mode_in   = 2'b00;
    bus.out_ready = 1'b1;
    bus.sat_clr   = 1'b0;

`ifndef MATH_ACCEL_AVG_EN
    vecs[0]  = '{SQ, 0,      0,    0};
    vecs[1]  = '{SQ, 16384,  1024, 0};
    vecs[2]  = '{SQ, -16384, 1024, 0};
    vecs[3]  = '{SQ, 32767,  4095, 0};
    vecs[4]  = '{SQ, -32768, 4095, 1};
    vecs[5]  = '{AB, -8,     1,    0};
    vecs[6]  = '{OF, -8,     2047, 0};
    vecs[7]  = '{MU, -8,     0,    0};
    vecs[8]  = '{OF, -32768, 0,    0};
    vecs[9]  = '{OF, 32767,  4095, 0};
    vecs[10] = '{OF, 0,      2048, 0};
    vecs[11] = '{AB, 100,    12,   0};
    vecs[12] = '{SQ, 1000,   3,    0};
    vecs[13] = '{AB, -32768, 4095, 1};
`endif

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_data_out",  int'(bus.data_out),  0);
    check("rst_sat_flag",  int'(bus.sat_flag),  0);
    check("rst_in_ready",  int'(bus.in_ready),  1);

`ifndef MATH_ACCEL_AVG_EN
    // single sample: out_valid rises exactly three cycles after the sample cycle
    send(SQ, 16384);
    idle();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k < 3) check("lat_early_valid", int'(bus.out_valid), 0);
      else begin
        check("lat_valid", int'(bus.out_valid), 1);
        check("lat_data",  int'(bus.data_out),  1024);
      end
      if (k < 3) @(posedge clk);
    end
    repeat (3) @(posedge clk);

    q_data.delete();
    q_sat.delete();
    foreach (vecs[i]) send(vecs[i].mode, vecs[i].x);
    idle();
    repeat (6) @(posedge clk);
    check("tbl_count", q_data.size(), 14);
    flag_m = 0;
    for (int i = 0; i < 14; i++) begin
      flag_m = flag_m | vecs[i].sat;
      if (i < q_data.size()) begin
        check($sformatf("tbl_data[%0d]", i), q_data[i], vecs[i].exp);
        check($sformatf("tbl_sat[%0d]", i),  q_sat[i],  flag_m);
      end
    end

    @(posedge clk);
    #1 bus.sat_clr = 1'b1;
    @(posedge clk);
    #1 bus.sat_clr = 1'b0;
    @(negedge clk);
    check("clr_flag", int'(bus.sat_flag), 0);

    // backpressure: out_ready low for 5 cycles while 6 samples stream in
    q_data.delete();
    q_sat.delete();
    fork
      begin
        for (int k = 1; k <= 6; k++) send(OF, k*1600 - 32768);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        held = 0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 0) held = int'(bus.data_out);
          check("bp_out_valid", int'(bus.out_valid), 1);
          check("bp_in_ready",  int'(bus.in_ready),  0);
          check("bp_data_held", int'(bus.data_out),  held);
          if (k < 4) @(posedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    check("bp_count", q_data.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < q_data.size()) check($sformatf("bp_data[%0d]", i), q_data[i], (i+1)*100);
    end
`endif

    // sat_clr in the very cycle a saturating result loads wins over the set
    send(SQ, -32768);
    idle();
    @(posedge clk);
    #1 bus.sat_clr = 1'b1;
    @(posedge clk);
    #1 bus.sat_clr = 1'b0;
    @(negedge clk);
    check("clr_vs_set_flag", int'(bus.sat_flag), 0);
`ifndef MATH_ACCEL_AVG_EN
    check("clr_vs_set_valid", int'(bus.out_valid), 1);
    check("clr_vs_set_data",  int'(bus.data_out),  4095);
`endif
    repeat (4) @(posedge clk);

    // async reset mid-stream drops outputs at once and discards in-flight samples
    for (int k = 0; k < 4; k++) send(SQ, 16384);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("arst_out_valid", int'(bus.out_valid), 0);
    check("arst_data_out",  int'(bus.data_out),  0);
    check("arst_in_ready",  int'(bus.in_ready),  1);
    check("arst_sat_flag",  int'(bus.sat_flag),  0);
    q_data.delete();
    q_sat.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    check("arst_no_leftover", q_data.size(), 0);

`ifdef MATH_ACCEL_AVG_EN
    // four equal squares average to one output, four cycles after the last sample
    for (int k = 0; k < 4; k++) send(SQ, 16384);
    idle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) check("avg_early_valid", int'(bus.out_valid), 0);
      if (k == 4) begin
        check("avg_valid", int'(bus.out_valid), 1);
        check("avg_data",  int'(bus.data_out),  1024);
      end
      if (k < 4) @(posedge clk);
    end
    repeat (4) @(posedge clk);
    check("avg_win1_count", q_data.size(), 1);

    // two squares then a mode change: the partial window is dropped
    q_data.delete();
    q_sat.delete();
    send(SQ, 16384);
    send(SQ, 16384);
    for (int k = 0; k < 3; k++) send(AB, 800);
    idle();
    repeat (8) @(posedge clk);
    check("avg_partial_none", q_data.size(), 0);
    send(AB, 800);
    idle();
    repeat (8) @(posedge clk);
    check("avg_win2_count", q_data.size(), 1);
    if (q_data.size() > 0) check("avg_win2_data", q_data[0], 100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
